// File: rtl/scr_ram_init_ctrl_if.sv
// ============================================================================
// Module      : scr_ram_init_ctrl_if
// Description : Request/grant RAM-style bus (host side and RAM side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scr_ram_init_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              gnt;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wmask;

    modport master (output req, write, addr, wdata, wmask, input gnt);
    modport slave  (input req, write, addr, wdata, wmask, output gnt);
endinterface

`default_nettype wire

// File: rtl/scr_ram_init_ctrl.sv
// ============================================================================
// Module      : scr_ram_init_ctrl
// Description : Key fetch, RAM scrub and host arbitration for the scrambled RAM.
//               Optional macro SCR_RAM_INIT_ZERO_FILL_EN: scrub with zeros, no LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scr_ram_init_ctrl #(
    parameter int          DEPTH       = 16384,
    parameter int          WIDTH       = 32,
    parameter int          NONCE_WIDTH = 64,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2357
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   init_req_i,
    output logic                        key_req_o,
    input  wire logic                   key_ack_i,
    input  wire logic [127:0]           key_data_i,
    input  wire logic [NONCE_WIDTH-1:0] nonce_data_i,
    output logic [127:0]                key_o,
    output logic [NONCE_WIDTH-1:0]      nonce_o,
    output logic                        key_valid_o,
    scr_ram_init_ctrl_if.slave          host,
    scr_ram_init_ctrl_if.master         ram,
    output logic                        busy_o,
    output logic                        init_done_o
);

    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  c_LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_KEY_REQ = 2'd1,
        ST_INIT    = 2'd2,
        ST_READY   = 2'd3
    } state_e;

    state_e                 state_q;
    logic [127:0]           key_q;
    logic [NONCE_WIDTH-1:0] nonce_q;
    logic                   key_valid_q;
    logic                   key_req_q;
    logic                   busy_q;
    logic                   init_done_q;
    logic [AW:0]            cnt_q;
    logic [AW:0]            cnt_d;
    logic [WIDTH-1:0]       w_init_data;

    assign cnt_d = cnt_q + 1'b1;

`ifdef SCR_RAM_INIT_ZERO_FILL_EN
    assign w_init_data = '0;
`else
    localparam logic [31:0] c_TAPS = 32'h8020_0003;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] w_seed_x;
    logic [31:0] w_seed;

    assign lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? c_TAPS : 32'h0);
    // An all-zero LFSR would lock up, so a zero seed falls back to the base seed.
    assign w_seed_x    = key_data_i[31:0] ^ LFSR_SEED;
    assign w_seed      = (w_seed_x == 32'h0) ? LFSR_SEED : w_seed_x;
    assign w_init_data = {(WIDTH/32){lfsr_q}};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RESET;
            key_q       <= '0;
            nonce_q     <= '0;
            key_valid_q <= 1'b0;
            key_req_q   <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            cnt_q       <= '0;
`ifndef SCR_RAM_INIT_ZERO_FILL_EN
            lfsr_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_q   <= ST_KEY_REQ;
                    key_req_q <= 1'b1;
                end
                ST_KEY_REQ: begin
                    if (key_ack_i) begin
                        state_q     <= ST_INIT;
                        key_q       <= key_data_i;
                        nonce_q     <= nonce_data_i;
                        key_valid_q <= 1'b1;
                        key_req_q   <= 1'b0;
                        cnt_q       <= '0;
`ifndef SCR_RAM_INIT_ZERO_FILL_EN
                        lfsr_q      <= w_seed;
`endif
                    end
                end
                ST_INIT: begin
                    if (ram.gnt) begin
                        cnt_q <= cnt_d;
`ifndef SCR_RAM_INIT_ZERO_FILL_EN
                        lfsr_q <= lfsr_d;
`endif
                        if (cnt_q == c_LAST) begin
                            state_q     <= ST_READY;
                            busy_q      <= 1'b0;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (init_req_i) begin
                        state_q     <= ST_KEY_REQ;
                        key_valid_q <= 1'b0;
                        key_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        init_done_q <= 1'b0;
                    end
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

    // The host only reaches the RAM once READY; otherwise the scrub engine owns it.
    always_comb begin
        ram.req   = 1'b0;
        ram.write = 1'b0;
        ram.addr  = cnt_q[AW-1:0];
        ram.wdata = w_init_data;
        ram.wmask = '1;
        host.gnt  = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram.req   = 1'b1;
                ram.write = 1'b1;
            end
            ST_READY: begin
                ram.req   = host.req;
                ram.write = host.write;
                ram.addr  = host.addr;
                ram.wdata = host.wdata;
                ram.wmask = host.wmask;
                host.gnt  = host.req & ram.gnt;
            end
            default: ;
        endcase
    end

    assign key_o       = key_q;
    assign nonce_o     = nonce_q;
    assign key_valid_o = key_valid_q;
    assign key_req_o   = key_req_q;
    assign busy_o      = busy_q;
    assign init_done_o = init_done_q;

endmodule

`default_nettype wire
